// File: rtl/qpsk_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_tx_sched_if
// Description : Source-side handshake and modulator-side frame bus for the
//               QPSK transmit frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface qpsk_tx_sched_if;
    logic        en;
    logic [1:0]  req;
    logic [23:0] payload0;
    logic [23:0] payload1;
    logic [1:0]  ack;
    logic [39:0] para_out;
    logic        frame_start;
    logic        busy;
    logic        grant_id;
    logic [15:0] frame_cnt;

    modport master (
        output en, req, payload0, payload1,
        input  ack, para_out, frame_start, busy, grant_id, frame_cnt
    );

    modport slave (
        input  en, req, payload0, payload1,
        output ack, para_out, frame_start, busy, grant_id, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/qpsk_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_tx_sched
// Description : Round-robin scheduler framing two 24-bit payload sources into
//               40-bit words held for one modulator slot each.
// Revision    : 1.0 - initial release
// ============================================================================
module qpsk_tx_sched #(
    parameter logic [7:0]  HEADER    = 8'hCC,
    parameter logic [15:0] FRAME_CYC = 16'd1000,
    parameter logic [39:0] IDLE_WORD = 40'h00_0000_0000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    qpsk_tx_sched_if.slave  bus
);

    localparam logic [15:0] c_LAST_CYC = FRAME_CYC - 16'd1;

    typedef enum logic [0:0] {
        SLOT_IDLE = 1'b0,
        SLOT_DATA = 1'b1
    } slot_state_t;

    slot_state_t r_state;
    slot_state_t w_state_nxt;

    logic [15:0] r_cnt;
    logic        r_rr;
    logic [39:0] r_para_out;
    logic [1:0]  r_ack;
    logic        r_frame_start;
    logic        r_grant_id;
    logic [15:0] r_frame_cnt;

    logic        w_decide;
    logic        w_grant;
    logic        w_win;
    logic [23:0] w_payload;
    logic [9:0]  w_sum;
    logic [39:0] w_frame;

    assign w_decide = (r_cnt == c_LAST_CYC);

    // Free-running slot counter; never influenced by en or req.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if (w_decide) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_grant     = bus.en && (bus.req != 2'b00);
        w_state_nxt = r_state;
        if (w_decide) begin
            w_state_nxt = w_grant ? SLOT_DATA : SLOT_IDLE;
        end
    end

    // A lone requester always wins; a tie goes to the preferred source.
    always_comb begin
        w_win = r_rr;
        case (bus.req)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            default: w_win = r_rr;
        endcase
    end

    always_comb begin
        w_payload = w_win ? bus.payload1 : bus.payload0;
        w_sum     = {2'b00, w_payload[23:16]}
                  + {2'b00, w_payload[15:8]}
                  + {2'b00, w_payload[7:0]};
        w_frame   = {HEADER, w_payload, w_sum[7:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_para_out    <= IDLE_WORD;
            r_ack         <= 2'b00;
            r_frame_start <= 1'b0;
            r_grant_id    <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_rr          <= 1'b0;
        end else begin
            r_ack         <= 2'b00;
            r_frame_start <= 1'b0;
            if (w_decide) begin
                r_frame_start <= 1'b1;
                if (w_state_nxt == SLOT_DATA) begin
                    r_para_out  <= w_frame;
                    r_ack       <= w_win ? 2'b10 : 2'b01;
                    r_grant_id  <= w_win;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                    r_rr        <= ~w_win;
                end else begin
                    r_para_out  <= IDLE_WORD;
                end
            end
        end
    end

    assign bus.para_out    = r_para_out;
    assign bus.ack         = r_ack;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = (r_state == SLOT_DATA);
    assign bus.grant_id    = r_grant_id;
    assign bus.frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
